// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Bridges the CPU's instruction-fetch and data SRAM-like ports onto one
//   single-beat AXI3 master. Reads from both sides share the AR channel and
//   are tagged by ID (0 = fetch, 1 = data). Responses are steered back to the
//   originating side by RID. Stores use the AW/W/B channels.
//   At most one fetch and one data access can be outstanding at a time.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   inst_sram_*              fetch side: req/size/addr in, addr_ok/data_ok/rdata out
//   data_sram_*              data side: req/wr/size/addr/wstrb/wdata in,
//                            addr_ok/data_ok/rdata out
//   arid/araddr/arsize/arvalid/arready   AXI read address channel
//   rid/rdata/rvalid/rready              AXI read data channel (rresp ignored)
//   awaddr/awsize/awvalid/awready        AXI write address channel
//   wdata/wstrb/wvalid/wready            AXI write data channel
//   bvalid/bready                        AXI write response channel
module sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic {R_IDLE, R_AR} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    r_state_t r_state, r_state_next;
    w_state_t w_state, w_state_next;

    logic inst_busy, data_busy;
    logic rd_data_accept, rd_inst_accept, wr_accept;
    logic inst_resp, data_rresp, data_bresp;
    logic aw_done, w_done;

    assign aw_done = awvalid & awready;
    assign w_done  = wvalid & wready;

    // Read responses are only honoured while the matching request is
    // outstanding, so stale beats after a reset are dropped. A store in
    // flight keeps the write FSM busy, which excludes a misrouted RID 1.
    assign inst_resp  = rvalid & (rid == 4'd0) & inst_busy;
    assign data_rresp = rvalid & (rid == 4'd1) & data_busy & (w_state == W_IDLE);

    // Read FSM: loads take priority over fetches.
    // NOTE: every signal written here gets a default first; a missing
    // assignment on any path would otherwise infer a latch.
    always_comb begin
        r_state_next   = r_state;
        rd_data_accept = 1'b0;
        rd_inst_accept = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (data_sram_req && !data_sram_wr && !data_busy) begin
                    rd_data_accept = 1'b1;
                    r_state_next   = R_AR;
                end else if (inst_sram_req && !inst_busy) begin
                    rd_inst_accept = 1'b1;
                    r_state_next   = R_AR;
                end
            end
            R_AR:    if (arready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Write FSM: a store yields to a load accepted in the same cycle.
    always_comb begin
        w_state_next = w_state;
        wr_accept    = 1'b0;
        data_bresp   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (data_sram_req && data_sram_wr && !data_busy && !rd_data_accept) begin
                    wr_accept    = 1'b1;
                    w_state_next = W_SEND;
                end
            end
            W_SEND: begin
                // Each channel counts as done if it handshakes now or already has.
                if ((aw_done || !awvalid) && (w_done || !wvalid))
                    w_state_next = W_RESP;
            end
            W_RESP: begin
                if (bvalid) begin
                    data_bresp   = 1'b1;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_state_next;
            w_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arid   <= 4'd0;
            araddr <= 32'd0;
            arsize <= 3'd0;
        end else if (rd_data_accept) begin
            arid   <= 4'd1;
            araddr <= data_sram_addr;
            arsize <= {1'b0, data_sram_size};
        end else if (rd_inst_accept) begin
            arid   <= 4'd0;
            araddr <= inst_sram_addr;
            arsize <= {1'b0, inst_sram_size};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awaddr  <= 32'd0;
            awsize  <= 3'd0;
            wdata   <= 32'd0;
            wstrb   <= 4'd0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (wr_accept) begin
            awaddr  <= data_sram_addr;
            awsize  <= {1'b0, data_sram_size};
            wdata   <= data_sram_wdata;
            wstrb   <= data_sram_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (aw_done) awvalid <= 1'b0;
            if (w_done)  wvalid  <= 1'b0;
        end
    end

    // Set wins over clear: a response and a new accept in the same cycle
    // leaves the side busy with the new request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_busy <= 1'b0;
            data_busy <= 1'b0;
        end else begin
            if (rd_inst_accept)  inst_busy <= 1'b1;
            else if (inst_resp)  inst_busy <= 1'b0;
            if (rd_data_accept || wr_accept)     data_busy <= 1'b1;
            else if (data_rresp || data_bresp)   data_busy <= 1'b0;
        end
    end

    assign arvalid = (r_state == R_AR);
    assign bready  = (w_state == W_RESP);
    assign rready  = ~reset;

    assign inst_sram_addr_ok = rd_inst_accept & ~reset;
    assign data_sram_addr_ok = (rd_data_accept | wr_accept) & ~reset;
    assign inst_sram_data_ok = inst_resp & ~reset;
    assign data_sram_data_ok = (data_rresp | data_bresp) & ~reset;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

endmodule
